hnm_pingpong: RTL and testbench

- Parametrised, double-buffered successor to the HNMPP hit map.
- Two NROWS x NCOLS bit-matrix banks:
  - the write bank accumulates SSID hits for event N;
  - the read bank serves SSID hit queries and whole-row readout for event N-1.
- SSID writes use a pipelined read-modify-write with forwarding, sustaining one write per cycle.
- A swap command exchanges the banks and hardware-clears the new write bank.
- Sits between hit clustering (SSID producer) and pattern matching (row/SSID consumer).

---
 rtl/hnm_pingpong_pkg.sv | 15 +
 rtl/hnm_bank.sv | 29 ++
 rtl/hnm_pingpong.sv | 214 +++++++++++++++++++++
 tb/tb_hnm_pingpong.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hnm_pingpong_pkg.sv
// Shared widths and FSM encoding for the double-buffered SSID hit map.
package hnm_pingpong_pkg;

  localparam int ROWBITS_HNM      = 7;
  localparam int NCOLS_HNM        = 13;
  localparam int COLINDEXBITS_HNM = $clog2(NCOLS_HNM);
  localparam int SSIDBITS         = ROWBITS_HNM + COLINDEXBITS_HNM;

  typedef enum logic [1:0] {
    INIT_CLR = 2'd0,
    RUN      = 2'd1,
    SWAP_CLR = 2'd2
  } hnm_state_t;

endpackage

// File: rtl/hnm_bank.sv
// One NROWS x NCOLS simple dual-port RAM with a registered read port.
// A read of the row being written in the same cycle returns the new data.
module hnm_bank #(
  parameter int ROWBITS = 7,
  parameter int NCOLS   = 13
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ROWBITS-1:0] waddr,
  input  logic [NCOLS-1:0]   wdata,
  input  logic [ROWBITS-1:0] raddr,
  output logic [NCOLS-1:0]   rdata
);

  logic [NCOLS-1:0] mem [2**ROWBITS];

  // Memory write and write-first synchronous read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/hnm_pingpong.sv
// Double-buffered SSID hit map: the write bank accumulates hits for the current
// event while the read bank serves SSID queries and row readout for the previous one.
module hnm_pingpong
  import hnm_pingpong_pkg::*;
#(
  parameter int ROWBITS = ROWBITS_HNM,
  parameter int NCOLS   = NCOLS_HNM,
  parameter int COLBITS = $clog2(NCOLS),
  parameter int CNTBITS = ROWBITS + COLBITS + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ROWBITS+COLBITS-1:0] wr_ssid,
  input  logic                       q_valid,
  output logic                       q_ready,
  input  logic [ROWBITS+COLBITS-1:0] q_ssid,
  output logic                       q_out_valid,
  output logic [ROWBITS+COLBITS-1:0] q_out_ssid,
  output logic                       q_out_hit,
  input  logic                       row_valid,
  output logic                       row_ready,
  input  logic [ROWBITS-1:0]         row_idx,
  output logic                       row_out_valid,
  output logic [ROWBITS-1:0]         row_out_idx,
  output logic [NCOLS-1:0]           row_out_data,
  input  logic                       swap,
  output logic                       swap_ready,
  output logic [CNTBITS-1:0]         set_count,
  output logic [15:0]                drop_count,
  output logic                       busy
);

  localparam int                 SB       = ROWBITS + COLBITS;
  localparam logic [ROWBITS-1:0] ROW_LAST = {ROWBITS{1'b1}};
  localparam logic [ROWBITS-1:0] ROW_ONE  = {{(ROWBITS-1){1'b0}}, 1'b1};
  localparam logic [CNTBITS-1:0] CNT_ONE  = {{(CNTBITS-1){1'b0}}, 1'b1};
  localparam logic [NCOLS-1:0]   BIT0     = {{(NCOLS-1){1'b0}}, 1'b1};
  localparam logic [COLBITS:0]   NCOLS_W  = (COLBITS+1)'(NCOLS);

  // Columns at or beyond NCOLS shift out and give an empty mask.
  function automatic logic [NCOLS-1:0] col_mask(input logic [COLBITS-1:0] col);
    return BIT0 << col;
  endfunction

  hnm_state_t         state, state_next;
  logic [ROWBITS-1:0] clr_row, clr_next;
  logic               wr_bank, clearing;
  logic [1:0]         is_wr, bank_we;
  logic [ROWBITS-1:0] bank_raddr [2];
  logic [NCOLS-1:0]   bank_rdata [2];
  logic [ROWBITS-1:0] bank_waddr;
  logic [NCOLS-1:0]   bank_wdata, wr_rdata;

  logic               wr_take, wr_drop;
  logic [ROWBITS-1:0] wr_row, s1_row, s2_row;
  logic [COLBITS-1:0] wr_col, s1_col;
  logic               s1_valid, s2_valid, s1_inc, s2_inc;
  logic [NCOLS-1:0]   s1_old, s1_new, s2_data;

  logic               rd_take_row, rd_take_q, p1_row_v, p1_q_v, p1_bank;
  logic [ROWBITS-1:0] rd_row;
  logic [SB-1:0]      p1_ssid;
  logic [NCOLS-1:0]   p1_data;

  assign wr_row      = wr_ssid[SB-1:COLBITS];
  assign wr_col      = wr_ssid[COLBITS-1:0];
  assign swap_ready  = swap & (state == RUN) & ~s1_valid & ~s2_valid;
  assign wr_ready    = (state == RUN) & ~swap_ready;
  assign row_ready   = (state != INIT_CLR);
  assign q_ready     = ~row_valid & (state != INIT_CLR);
  assign wr_take     = wr_valid & wr_ready;
  assign wr_drop     = wr_take & ({1'b0, wr_col} >= NCOLS_W);
  assign rd_take_row = row_valid & row_ready;
  assign rd_take_q   = q_valid & q_ready;
  assign rd_row      = row_valid ? row_idx : q_ssid[SB-1:COLBITS];

  // During a sweep the write port belongs to the clear; INIT_CLR hits both banks.
  assign is_wr      = wr_bank ? 2'b10 : 2'b01;
  assign clearing   = (state != RUN);
  assign bank_waddr = clearing ? clr_row : s2_row;
  assign bank_wdata = clearing ? {NCOLS{1'b0}} : s2_data;
  assign wr_rdata   = wr_bank ? bank_rdata[1] : bank_rdata[0];
  assign p1_data    = p1_bank ? bank_rdata[1] : bank_rdata[0];

  for (genvar g = 0; g < 2; g++) begin : g_bank
    assign bank_we[g]    = (state == INIT_CLR) | (is_wr[g] & ((state == SWAP_CLR) | s2_valid));
    assign bank_raddr[g] = is_wr[g] ? wr_row : rd_row;

    hnm_bank #(.ROWBITS(ROWBITS), .NCOLS(NCOLS)) u_bank (
      .clk   (clk),
      .we    (bank_we[g]),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .raddr (bank_raddr[g]),
      .rdata (bank_rdata[g])
    );
  end

  // S1 merge: forward the row S2 is writing when S1 reads the same row.
  always_comb begin
    s1_old = (s2_valid && (s2_row == s1_row)) ? s2_data : wr_rdata;
    s1_new = s1_old | col_mask(s1_col);
    s1_inc = ~|(s1_old & col_mask(s1_col));
  end

  // Next-state and clear-row sequencing.
  always_comb begin
    state_next = state;
    clr_next   = clr_row;
    case (state)
      INIT_CLR, SWAP_CLR: begin
        clr_next = clr_row + ROW_ONE;
        if (clr_row == ROW_LAST) state_next = RUN;
        else                     state_next = state;
      end
      RUN: begin
        if (swap_ready) begin
          state_next = SWAP_CLR;
          clr_next   = {ROWBITS{1'b0}};
        end else begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = INIT_CLR;
        clr_next   = {ROWBITS{1'b0}};
      end
    endcase
  end

  // FSM state, sweep row, bank select and busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= INIT_CLR;
      clr_row <= {ROWBITS{1'b0}};
      wr_bank <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      clr_row <= clr_next;
      busy    <= (state_next != RUN);
      if (swap_ready) wr_bank <= ~wr_bank;
    end
  end

  // Write pipeline registers and hit/drop counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_row     <= {ROWBITS{1'b0}};
      s1_col     <= {COLBITS{1'b0}};
      s2_valid   <= 1'b0;
      s2_row     <= {ROWBITS{1'b0}};
      s2_data    <= {NCOLS{1'b0}};
      s2_inc     <= 1'b0;
      set_count  <= {CNTBITS{1'b0}};
      drop_count <= 16'd0;
    end else begin
      s1_valid <= wr_take & ~wr_drop;
      if (wr_take) begin
        s1_row <= wr_row;
        s1_col <= wr_col;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_row  <= s1_row;
        s2_data <= s1_new;
        s2_inc  <= s1_inc;
      end
      if (swap_ready)              set_count <= {CNTBITS{1'b0}};
      else if (s2_valid && s2_inc) set_count <= set_count + CNT_ONE;
      if (wr_drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

  // Read port: the bank is latched at issue so a same-cycle swap still reads the old bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_row_v      <= 1'b0;
      p1_q_v        <= 1'b0;
      p1_bank       <= 1'b0;
      p1_ssid       <= {SB{1'b0}};
      row_out_valid <= 1'b0;
      row_out_idx   <= {ROWBITS{1'b0}};
      row_out_data  <= {NCOLS{1'b0}};
      q_out_valid   <= 1'b0;
      q_out_ssid    <= {SB{1'b0}};
      q_out_hit     <= 1'b0;
    end else begin
      p1_row_v <= rd_take_row;
      p1_q_v   <= rd_take_q;
      if (rd_take_row) begin
        p1_ssid <= {row_idx, {COLBITS{1'b0}}};
        p1_bank <= ~wr_bank;
      end else if (rd_take_q) begin
        p1_ssid <= q_ssid;
        p1_bank <= ~wr_bank;
      end
      row_out_valid <= p1_row_v;
      q_out_valid   <= p1_q_v;
      if (p1_row_v) begin
        row_out_idx  <= p1_ssid[SB-1:COLBITS];
        row_out_data <= p1_data;
      end
      if (p1_q_v) begin
        q_out_ssid <= p1_ssid;
        q_out_hit  <= |(p1_data & col_mask(p1_ssid[COLBITS-1:0]));
      end
    end
  end

endmodule

// File: tb/tb_hnm_pingpong.sv
// Directed bench for hnm_pingpong: clears, bank swaps, forwarding, drops, reset abort.
module tb_hnm_pingpong;
  import hnm_pingpong_pkg::*;

  localparam int NROWS = 128;
  localparam int SB    = SSIDBITS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0, q_valid = 1'b0, row_valid = 1'b0, swap = 1'b0;
  logic [SB-1:0] wr_ssid = '0, q_ssid = '0;
  logic [6:0]    row_idx = '0;
  logic          wr_ready, q_ready, row_ready, swap_ready, busy;
  logic          q_out_valid, q_out_hit, row_out_valid;
  logic [SB-1:0] q_out_ssid;
  logic [6:0]    row_out_idx;
  logic [12:0]   row_out_data;
  logic [11:0]   set_count;
  logic [15:0]   drop_count;

  int checks = 0;
  int errors = 0;
  int k;
  int m;

  always #5 clk = ~clk;

  hnm_pingpong dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ssid(wr_ssid),
    .q_valid(q_valid), .q_ready(q_ready), .q_ssid(q_ssid),
    .q_out_valid(q_out_valid), .q_out_ssid(q_out_ssid), .q_out_hit(q_out_hit),
    .row_valid(row_valid), .row_ready(row_ready), .row_idx(row_idx),
    .row_out_valid(row_out_valid), .row_out_idx(row_out_idx), .row_out_data(row_out_data),
    .swap(swap), .swap_ready(swap_ready),
    .set_count(set_count), .drop_count(drop_count), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SB-1:0] mk(input int row, input int col);
    return SB'((row << 4) | col);
  endfunction

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    check("busy_idle", busy, 0);
  endtask

  task automatic init_seq();
    int w;
    reset = 1'b0;
    tick();
    check("busy_rise", busy, 1);
    check("no_ready_in_init", {row_ready, q_ready, wr_ready, swap_ready}, 0);
    wait_idle(w);
    check("init_cycles", w + 1, NROWS);
    check("wr_ready_run", wr_ready, 1);
  endtask

  task automatic wr(input logic [SB-1:0] s);
    wr_valid = 1'b1;
    wr_ssid  = s;
    #1;
    check("wr_ready", wr_ready, 1);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_swap(input int exp_cnt);
    int n = 0;
    swap = 1'b1;
    #1;
    while (swap_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("swap_ready", swap_ready, 1);
    check("wr_hold_on_swap", wr_ready, 0);
    check("set_count_pre_swap", set_count, exp_cnt);
    tick();
    swap = 1'b0;
    check("set_count_cleared", set_count, 0);
    check("busy_on_swap", busy, 1);
  endtask

  task automatic read_row(input int idx, input logic [12:0] exp);
    row_valid = 1'b1;
    row_idx   = 7'(idx);
    #1;
    check("row_ready", row_ready, 1);
    tick();
    row_valid = 1'b0;
    check("row_lat1", row_out_valid, 0);
    tick();
    check("row_out_valid", row_out_valid, 1);
    check("row_out_idx", row_out_idx, idx);
    check("row_out_data", row_out_data, exp);
  endtask

  task automatic read_all_zero();
    for (int r = 0; r < NROWS; r++) read_row(r, 13'h0);
  endtask

  task automatic query(input logic [SB-1:0] s, input logic exp_hit);
    q_valid = 1'b1;
    q_ssid  = s;
    #1;
    check("q_ready", q_ready, 1);
    tick();
    q_valid = 1'b0;
    check("q_lat1", q_out_valid, 0);
    tick();
    check("q_out_valid", q_out_valid, 1);
    check("q_out_ssid", q_out_ssid, s);
    check("q_out_hit", q_out_hit, exp_hit);
  endtask

  task automatic check_reset_outputs();
    check("rst_ctrl", {busy, wr_ready, q_ready, row_ready, swap_ready, q_out_valid, row_out_valid}, 0);
    check("rst_set_count", set_count, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_q_out", {q_out_ssid, q_out_hit}, 0);
    check("rst_row_out", {row_out_idx, row_out_data}, 0);
  endtask

  initial begin
    // Reset, initial clear, first swap, all rows read back zero.
    tick();
    tick();
    check_reset_outputs();
    init_seq();
    do_swap(0);
    wait_idle(m);
    check("swapclr_cycles", m, NROWS);
    read_all_zero();

    // Back-to-back writes into row 8 including duplicates.
    wr(mk(8, 0));
    wr(mk(8, 3));
    wr(mk(8, 7));
    wr(mk(8, 8));
    wr(mk(8, 8));
    wr(mk(8, 8));
    wr_valid = 1'b0;
    swap = 1'b1;
    #1;
    check("swap_wait_pipe", swap_ready, 0);
    do_swap(4);
    wait_idle(m);
    read_row(8, 13'h189);

    // Same-row forwarding case, then queries on the new read bank.
    wr(mk(4, 12));
    wr(mk(4, 4));
    wr(mk(4, 4));
    wr_valid = 1'b0;
    do_swap(2);
    wait_idle(m);
    query(mk(4, 4), 1'b1);
    query(mk(4, 5), 1'b0);
    query(mk(4, 12), 1'b1);
    query(mk(4, 15), 1'b0);
    read_row(4, 13'h1010);

    // Column beyond NCOLS is dropped.
    wr(mk(9, 13));
    wr_valid = 1'b0;
    idle(3);
    check("drop_count", drop_count, 1);
    check("set_count_after_drop", set_count, 0);

    // Query accepted together with a swap sees the old read bank.
    wr(mk(8, 3));
    wr_valid = 1'b0;
    idle(3);
    check("set_count_83", set_count, 1);
    swap    = 1'b1;
    q_valid = 1'b1;
    q_ssid  = mk(8, 3);
    #1;
    check("swap_ready_same", swap_ready, 1);
    check("q_ready_same", q_ready, 1);
    tick();
    swap    = 1'b0;
    q_valid = 1'b0;
    check("busy_swapclr", busy, 1);
    tick();
    check("q_same_valid", q_out_valid, 1);
    check("q_same_ssid", q_out_ssid, mk(8, 3));
    check("q_same_hit_old_bank", q_out_hit, 0);
    k = 2;
    query(mk(8, 3), 1'b1);
    k += 2;
    read_row(9, 13'h0);
    k += 2;
    while (k < 40) begin
      tick();
      k++;
    end

    // Reset in the middle of the swap clear sweep.
    check("busy_mid_sweep", busy, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    tick();
    tick();
    check_reset_outputs();
    init_seq();
    read_all_zero();
    do_swap(0);
    wait_idle(m);
    read_all_zero();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
